mem_access_unit: RTL and testbench

- Data-memory access stage, directly downstream of the funct3 load/store decoder; consumes its `LoadType`/`StoreType` codes plus the effective address and store data from execute.
- Generates a word-aligned memory request with byte enables, waits on a memory ack handshake with a timeout, and returns a sign/zero-extended load result or store completion to writeback.
- Flags misaligned and illegal accesses, and memory timeouts, without issuing or completing a bus cycle.

---
 rtl/mem_access_unit_pkg.sv | 12 +
 rtl/mem_access_unit_load_extend.sv | 20 ++
 rtl/mem_access_unit.sv | 111 +++++++++++
 tb/tb_mem_access_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: load/store type codes and FSM state encoding for the data-memory access stage
package mem_access_unit_pkg;
  localparam logic [2:0] LT_WORD  = 3'b000;
  localparam logic [2:0] LT_BYTE  = 3'b010;
  localparam logic [2:0] LT_HALF  = 3'b101;
  localparam logic [2:0] LT_BYTEU = 3'b001;
  localparam logic [2:0] LT_HALFU = 3'b100;
  localparam logic [1:0] ST_WORD  = 2'b00;
  localparam logic [1:0] ST_BYTE  = 2'b01;
  localparam logic [1:0] ST_HALF  = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} state_e;
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// mem_access_unit_load_extend: selects the addressed lane of a read word and sign/zero-extends it
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = word[{offset, 3'b000} +: 8];
    h    = offset[1] ? word[31:16] : word[15:0];
    data = load_type == LT_BYTE  ? {{24{b[7]}}, b} :
           load_type == LT_BYTEU ? {24'b0, b} :
           load_type == LT_HALF  ? {{16{h[15]}}, h} :
           load_type == LT_HALFU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage with lane formatting, ack timeout and extended load return
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_misalign,
  output logic              rsp_bus_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_e      state;
  logic [CW-1:0] cnt;
  logic        st_r;
  logic [2:0]  lt_r;
  logic [1:0]  off_r;
  logic [31:0] ext;
  logic        byte_a, half_a, word_a, bad_a;
  logic [3:0]  be_a;
  logic [31:0] wd_a;
  always_comb begin
    byte_a = is_store ? store_type == ST_BYTE : (load_type == LT_BYTE || load_type == LT_BYTEU);
    half_a = is_store ? store_type == ST_HALF : (load_type == LT_HALF || load_type == LT_HALFU);
    word_a = is_store ? store_type == ST_WORD : load_type == LT_WORD;
    bad_a  = !(byte_a || half_a || word_a) || (half_a && addr[0]) || (word_a && addr[1:0] != 2'b00);
    be_a   = byte_a ? 4'b0001 << addr[1:0] : half_a ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_a   = byte_a ? {4{wdata[7:0]}} : half_a ? {2{wdata[15:0]}} : wdata;
  end
  mem_access_unit_load_extend u_load_extend (
    .load_type(lt_r),
    .offset   (off_r),
    .word     (mem_rdata),
    .data     (ext)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      st_r         <= 1'b0;
      lt_r         <= '0;
      off_r        <= '0;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_misalign <= 1'b0;
      rsp_bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          st_r      <= is_store;
          lt_r      <= load_type;
          off_r     <= addr[1:0];
          mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
          mem_be    <= be_a;
          mem_wdata <= wd_a;
          cnt       <= '0;
          req_ready <= 1'b0;
          rsp_data  <= '0;
          // faulting accesses skip the bus entirely
          state        <= bad_a ? RESP : WAIT_MEM;
          mem_req      <= !bad_a;
          mem_we       <= !bad_a && is_store;
          rsp_valid    <= bad_a;
          rsp_misalign <= bad_a;
        end
        WAIT_MEM: if (mem_ack || cnt == LAST) begin
          state       <= RESP;
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_bus_err <= !mem_ack;
          rsp_data    <= (mem_ack && !st_r) ? ext : 32'b0;
        end else
          cnt <= cnt + 1'b1;
        RESP: if (rsp_ready) begin
          state        <= IDLE;
          req_ready    <= 1'b1;
          rsp_valid    <= 1'b0;
          rsp_data     <= '0;
          rsp_misalign <= 1'b0;
          rsp_bus_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed table, corner sequences and randomized model checks for mem_access_unit
module tb_mem_access_unit;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, is_store = 0;
  logic [2:0] load_type = 0;
  logic [1:0] store_type = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_be;
  logic rsp_valid, rsp_ready = 0, rsp_misalign, rsp_bus_err;
  logic [31:0] rsp_data;
  int checks = 0, errors = 0;

  typedef struct {
    logic s; logic [2:0] lt; logic [1:0] st; logic [31:0] a, wd, rd; int ackd, hold;
    logic [3:0] be; logic [31:0] ewd, ed; logic mis, berr;
  } vec_t;
  vec_t tbl[13];

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .load_type(load_type), .store_type(store_type), .addr(addr),
    .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_misalign(rsp_misalign), .rsp_bus_err(rsp_bus_err));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int sz, off;
    longint lane;
    if (v.s) sz = v.st == 2'd0 ? 4 : v.st == 2'd1 ? 1 : v.st == 2'd2 ? 2 : 0;
    else case (v.lt)
      3'd0: sz = 4;
      3'd1, 3'd2: sz = 1;
      3'd4, 3'd5: sz = 2;
      default: sz = 0;
    endcase
    off = int'(v.a % 4);
    r.mis = sz == 0 || (off % sz) != 0;
    r.berr = !r.mis && (v.ackd == 0 || v.ackd > TO);
    r.be = r.mis ? 4'd0 : 4'(((1 << sz) - 1) << off);
    r.ewd = sz == 1 ? {24'd0, v.wd[7:0]} * 32'h01010101 : sz == 2 ? {16'd0, v.wd[15:0]} * 32'h00010001 : v.wd;
    r.ed = 0;
    if (!r.mis && !r.berr && !v.s) begin
      lane = (longint'(v.rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
      if ((v.lt == 3'd2 || v.lt == 3'd5) && lane >= (64'd1 << (8 * sz - 1))) lane -= 64'd1 << (8 * sz);
      r.ed = lane[31:0];
    end
    return r;
  endfunction

  task automatic access(input vec_t v);
    int n = 0;
    @(posedge clk); #1;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; is_store = v.s; load_type = v.lt; store_type = v.st; addr = v.a; wdata = v.wd;
    @(posedge clk); #1;
    req_valid = 0; addr = $urandom; wdata = $urandom;
    if (v.mis) begin
      chk("misalign_no_req", mem_req, 0);
      chk("misalign_rsp_cycle1", rsp_valid, 1);
    end else begin
      chk("mem_req_cycle1", mem_req, 1);
      chk("mem_addr", mem_addr, v.a & 32'hFFFF_FFFC);
      chk("mem_be", mem_be, v.be);
      chk("mem_we", mem_we, v.s);
      if (v.s) chk("mem_wdata", mem_wdata, v.ewd);
      while (mem_req && n < TO + 4) begin
        n++;
        if (n == v.ackd) begin mem_ack = 1; mem_rdata = v.rd; end
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = $urandom;
      end
      chk("req_cycles", n, v.berr ? TO : v.ackd);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, v.ed);
    chk("rsp_misalign", rsp_misalign, v.mis);
    chk("rsp_bus_err", rsp_bus_err, v.berr);
    chk("req_ready_busy", req_ready, 0);
    repeat (v.hold) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, v.ed);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("flags_clear", {rsp_misalign, rsp_bus_err}, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    vec_t v;
    // s lt st addr wdata rdata ackd hold | be wdata data mis berr
    tbl[0]  = '{1'b1, 3'd0, 2'd0, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd0, 2'd1, 32'h103, 32'h000000A5, 32'h0, 2, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'd2, 2'd0, 32'h202, 32'h0, 32'h12805634, 1, 0, 4'b0100, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 3'd1, 2'd0, 32'h202, 32'h0, 32'h12805634, 1, 0, 4'b0100, 32'h0, 32'h00000080, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'd4, 2'd0, 32'h202, 32'h0, 32'h12805634, 3, 0, 4'b1100, 32'h0, 32'h00001280, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'd5, 2'd0, 32'h301, 32'h0, 32'h0, 1, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd3, 2'd0, 32'h300, 32'h0, 32'h0, 1, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 2'd0, 32'h400, 32'h0, 32'h0, 0, 1, 4'b1111, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 3'd0, 2'd0, 32'h404, 32'h0, 32'hCAFEF00D, 16, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 2'd2, 32'h106, 32'h1234BEEF, 32'h0, 1, 5, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd0, 2'd0, 32'h102, 32'h11111111, 32'h0, 1, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 3'd0, 2'd3, 32'h100, 32'h11111111, 32'h0, 1, 0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 3'd5, 2'd0, 32'h3FE, 32'h0, 32'h80017777, 3, 5, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_rsp_data", rsp_data, 0);
    @(negedge clk); rst_n = 1;
    foreach (tbl[i]) access(tbl[i]);
    // stray ack and rsp_ready in IDLE must do nothing
    @(posedge clk); #1;
    mem_ack = 1; rsp_ready = 1;
    @(posedge clk); #1;
    mem_ack = 0; rsp_ready = 0;
    chk("idle_ack_ignored", {rsp_valid, mem_req, req_ready}, 3'b001);
    // reset while waiting on memory
    @(posedge clk); #1;
    req_valid = 1; is_store = 0; load_type = 3'd0; addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_mem_req", mem_req, 1);
    rst_n = 0;
    #1;
    chk("async_reset_mem_req", mem_req, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("post_reset_req_ready", req_ready, 1);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    for (int k = 0; k < 60; k++) begin
      v.s = 1'($urandom);
      v.lt = 3'($urandom);
      v.st = 2'($urandom);
      v.a = $urandom;
      if ($urandom_range(0, 1) == 0) v.a[1:0] = 2'b00;
      v.wd = $urandom;
      v.rd = $urandom;
      v.ackd = $urandom_range(0, 5) == 0 ? $urandom_range(0, TO) : $urandom_range(1, 4);
      v.hold = $urandom_range(0, 2);
      access(model(v));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
